// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-oriented I2C master.
// Each grant runs one address+data exchange, a post-transfer hold and a watchdog.
module i2c_arbiter #(
    parameter int HOLD_CYCLES    = 100,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [1:0]  req,
    input  logic [13:0] req_addr,
    input  logic [1:0]  req_rnw,
    input  logic [15:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic        timeout,
    output logic        ena_i2c,
    output logic [7:0]  adrr_r_w,
    output logic [7:0]  byte_2_send,
    input  logic [7:0]  byte_received,
    input  logic        end_trans
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ADDR = 3'd2,
        WAIT_DATA = 3'd3,
        HOLD      = 3'd4,
        WAIT_FALL = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

    state_t          state_r;
    state_t          next_state_s;
    logic            end_trans_q_r;
    logic            rise_s;
    logic            active_s;
    logic            wd_expired_s;
    logic            hold_last_s;
    logic [HW-1:0]   hold_cnt_r;
    logic [WW-1:0]   wd_cnt_r;
    logic            winner_s;
    logic            winner_r;
    logic            last_r;
    logic            rnw_r;
    logic [6:0]      sel_addr_s;
    logic            sel_rnw_s;
    logic [7:0]      sel_wdata_s;

    // Edge detect and status decodes
    always_comb begin
        rise_s       = end_trans & ~end_trans_q_r;
        active_s     = (state_r == WAIT_ADDR) || (state_r == WAIT_DATA) ||
                       (state_r == HOLD)      || (state_r == WAIT_FALL);
        wd_expired_s = active_s && (wd_cnt_r == WD_LAST);
        hold_last_s  = (hold_cnt_r == HOLD_LAST);
    end

    // Round-robin pick: last_r names the requester served most recently
    always_comb begin
        winner_s    = 1'b0;
        sel_addr_s  = req_addr[6:0];
        sel_rnw_s   = req_rnw[0];
        sel_wdata_s = req_wdata[7:0];
        if (req == 2'b10) begin
            winner_s = 1'b1;
        end else if (req == 2'b11) begin
            winner_s = ~last_r;
        end else begin
            winner_s = 1'b0;
        end
        if (winner_s) begin
            sel_addr_s  = req_addr[13:7];
            sel_rnw_s   = req_rnw[1];
            sel_wdata_s = req_wdata[15:8];
        end else begin
            sel_addr_s  = req_addr[6:0];
            sel_rnw_s   = req_rnw[0];
            sel_wdata_s = req_wdata[7:0];
        end
    end

    // Next-state logic; watchdog expiry overrides every active-state transition
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) next_state_s = LOAD;
                else              next_state_s = IDLE;
            end
            LOAD: next_state_s = WAIT_ADDR;
            WAIT_ADDR: begin
                if (wd_expired_s) next_state_s = DONE;
                else if (rise_s)  next_state_s = WAIT_DATA;
                else              next_state_s = WAIT_ADDR;
            end
            WAIT_DATA: begin
                if (wd_expired_s) next_state_s = DONE;
                else if (rise_s)  next_state_s = HOLD;
                else              next_state_s = WAIT_DATA;
            end
            HOLD: begin
                if (wd_expired_s)     next_state_s = DONE;
                else if (hold_last_s) next_state_s = WAIT_FALL;
                else                  next_state_s = HOLD;
            end
            WAIT_FALL: begin
                if (wd_expired_s || !end_trans) next_state_s = DONE;
                else                            next_state_s = WAIT_FALL;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // end_trans history for rise detection
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) end_trans_q_r <= 1'b0;
        else        end_trans_q_r <= end_trans;
    end

    // Hold and watchdog counters
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hold_cnt_r <= {HW{1'b0}};
            wd_cnt_r   <= {WW{1'b0}};
        end else begin
            if (state_r == HOLD) hold_cnt_r <= hold_cnt_r + HW'(1);
            else                 hold_cnt_r <= {HW{1'b0}};
            if (state_r == LOAD)  wd_cnt_r <= {WW{1'b0}};
            else if (active_s)    wd_cnt_r <= wd_cnt_r + WW'(1);
            else                  wd_cnt_r <= wd_cnt_r;
        end
    end

    // Grant, transfer registers, I2C enable and completion pulses
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            gnt         <= 2'b00;
            done        <= 2'b00;
            timeout     <= 1'b0;
            ena_i2c     <= 1'b0;
            adrr_r_w    <= 8'h00;
            byte_2_send <= 8'h00;
            rdata       <= 8'h00;
            winner_r    <= 1'b0;
            rnw_r       <= 1'b0;
            last_r      <= 1'b1;
        end else begin
            done    <= 2'b00;
            timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (next_state_s == LOAD) begin
                        winner_r    <= winner_s;
                        gnt         <= winner_s ? 2'b10 : 2'b01;
                        adrr_r_w    <= {sel_addr_s, sel_rnw_s};
                        byte_2_send <= sel_rnw_s ? 8'h00 : sel_wdata_s;
                        rnw_r       <= sel_rnw_s;
                    end
                end
                LOAD: ena_i2c <= 1'b1;
                WAIT_ADDR, WAIT_DATA, HOLD, WAIT_FALL: begin
                    if (next_state_s == DONE) begin
                        ena_i2c <= 1'b0;
                        done    <= gnt;
                        timeout <= wd_expired_s;
                    end else if ((state_r == HOLD) && (next_state_s == WAIT_FALL)) begin
                        ena_i2c <= 1'b0;
                        if (rnw_r) rdata <= byte_received;
                    end
                end
                DONE: begin
                    gnt    <= 2'b00;
                    last_r <= winner_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: table of single transactions, then round-robin,
// watchdog and asynchronous-reset sequences.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        arstn;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [1:0]  req_rnw;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        timeout;
    logic        ena_i2c;
    logic [7:0]  adrr_r_w;
    logic [7:0]  byte_2_send;
    logic [7:0]  byte_received;
    logic        end_trans;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic [13:0] addr;
        logic [1:0]  rnw;
        logic [15:0] wdata;
        logic [7:0]  slave;
        logic        glitch;
        logic [1:0]  exp_gnt;
        logic [7:0]  exp_adrr;
        logic [7:0]  exp_b2s;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    i2c_arbiter #(.HOLD_CYCLES(100), .TIMEOUT_CYCLES(1000)) dut (
        .clk           (clk),
        .arstn         (arstn),
        .req           (req),
        .req_addr      (req_addr),
        .req_rnw       (req_rnw),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .done          (done),
        .rdata         (rdata),
        .timeout       (timeout),
        .ena_i2c       (ena_i2c),
        .adrr_r_w      (adrr_r_w),
        .byte_2_send   (byte_2_send),
        .byte_received (byte_received),
        .end_trans     (end_trans)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // gnt must never carry two bits
    always @(negedge clk) begin
        checks++;
        if (gnt === 2'b11) begin
            errors++;
            $display("FAIL gnt_onehot actual=%0h expected=one-hot", gnt);
        end
    end

    // One transaction; req/addr/data must already be applied while IDLE
    task automatic run_txn(input string tag, input logic [1:0] exp_gnt, input logic [7:0] exp_adrr,
                           input logic [7:0] exp_b2s, input logic [7:0] exp_rdata,
                           input logic glitch, input logic keep_req);
        logic got;
        int   hold_n;
        got = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_gnt_seen"}, 32'(got), 32'd1);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_adrr"}, 32'(adrr_r_w), 32'(exp_adrr));
        check({tag, "_b2s"}, 32'(byte_2_send), 32'(exp_b2s));
        check({tag, "_ena_load"}, 32'(ena_i2c), 32'd0);
        @(negedge clk);
        check({tag, "_ena_addr"}, 32'(ena_i2c), 32'd1);
        if (!keep_req) begin
            req       = 2'b00;
            req_addr  = 14'h3FFF;
            req_wdata = 16'hFFFF;
            req_rnw   = ~req_rnw;
        end
        end_trans = 1'b1;
        @(negedge clk);
        end_trans = 1'b0;
        @(negedge clk);
        check({tag, "_ena_data"}, 32'(ena_i2c), 32'd1);
        end_trans = 1'b1;
        hold_n = 0;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!ena_i2c) begin
                got = 1'b1;
                break;
            end
            hold_n++;
            if (glitch) begin
                if (c == 10) end_trans = 1'b0;
                if (c == 20) end_trans = 1'b1;
                if (c == 30) end_trans = 1'b0;
            end
        end
        check({tag, "_hold_end"}, 32'(got), 32'd1);
        check({tag, "_hold_cycles"}, 32'(hold_n), 32'd100);
        check({tag, "_done_hold"}, 32'(done), 32'd0);
        if (end_trans) begin
            repeat (3) @(negedge clk);
            check({tag, "_done_early"}, 32'(done), 32'd0);
            end_trans = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_gnt));
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        check({tag, "_adrr_stable"}, 32'(adrr_r_w), 32'(exp_adrr));
        check({tag, "_b2s_stable"}, 32'(byte_2_send), 32'(exp_b2s));
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic got;
        int   cnt;
        arstn = 1'b0; req = 2'b00; req_addr = 14'h0000; req_rnw = 2'b00;
        req_wdata = 16'h0000; byte_received = 8'h00; end_trans = 1'b0;

        vecs[0] = '{2'b01, {7'h11, 7'h34}, 2'b10, {8'h99, 8'h34}, 8'hAA, 1'b0, 2'b01, 8'h68, 8'h34, 8'h00};
        vecs[1] = '{2'b10, {7'h34, 7'h55}, 2'b10, {8'h77, 8'h12}, 8'h29, 1'b0, 2'b10, 8'h69, 8'h00, 8'h29};
        vecs[2] = '{2'b01, {7'h0F, 7'h50}, 2'b01, {8'h44, 8'h5C}, 8'hC3, 1'b0, 2'b01, 8'hA1, 8'h00, 8'hC3};
        vecs[3] = '{2'b10, {7'h7F, 7'h01}, 2'b01, {8'hE5, 8'h3D}, 8'h11, 1'b0, 2'b10, 8'hFE, 8'hE5, 8'hC3};
        vecs[4] = '{2'b01, {7'h00, 7'h12}, 2'b01, 16'h0000,       8'h5A, 1'b1, 2'b01, 8'h25, 8'h00, 8'h5A};

        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_ena", 32'(ena_i2c), 32'd0);
        check("rst_adrr", 32'(adrr_r_w), 32'd0);
        check("rst_b2s", 32'(byte_2_send), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            req_addr      = vecs[i].addr;
            req_rnw       = vecs[i].rnw;
            req_wdata     = vecs[i].wdata;
            byte_received = vecs[i].slave;
            end_trans     = 1'b0;
            req           = vecs[i].req;
            run_txn($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_adrr, vecs[i].exp_b2s,
                    vecs[i].exp_rdata, vecs[i].glitch, 1'b0);
        end

        // Fresh reset, then both requesters held: grants alternate starting at 0
        @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        check("rr_rst_rdata", 32'(rdata), 32'd0);
        arstn = 1'b1;
        req_addr = {7'h0B, 7'h0A}; req_rnw = 2'b00; req_wdata = {8'hB1, 8'hA1};
        byte_received = 8'h5E; req = 2'b11;
        run_txn("rr0", 2'b01, 8'h14, 8'hA1, 8'h00, 1'b0, 1'b1);
        run_txn("rr1", 2'b10, 8'h16, 8'hB1, 8'h00, 1'b0, 1'b1);
        run_txn("rr2", 2'b01, 8'h14, 8'hA1, 8'h00, 1'b0, 1'b1);
        req = 2'b00;

        // Watchdog: end_trans stays low, read must not update rdata
        req_addr = {7'h00, 7'h2A}; req_rnw = 2'b01; byte_received = 8'h77;
        end_trans = 1'b0; req = 2'b01;
        got = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("to_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (!ena_i2c) begin
                got = 1'b1;
                break;
            end
            cnt++;
        end
        check("to_end_seen", 32'(got), 32'd1);
        check("to_ena_cycles", 32'(cnt), 32'd1000);
        check("to_done", 32'(done), 32'd1);
        check("to_flag", 32'(timeout), 32'd1);
        @(negedge clk);
        check("to_done_clr", 32'(done), 32'd0);
        check("to_flag_clr", 32'(timeout), 32'd0);
        check("to_rdata", 32'(rdata), 32'd0);
        check("to_gnt_clr", 32'(gnt), 32'd0);

        // Asynchronous reset while in WAIT_DATA
        req_addr = {7'h22, 7'h00}; req_rnw = 2'b00; req_wdata = {8'h66, 8'h00}; req = 2'b10;
        got = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("ar_gnt", 32'(gnt), 32'd2);
        @(negedge clk);
        req = 2'b00;
        end_trans = 1'b1;
        @(negedge clk);
        check("ar_ena_before", 32'(ena_i2c), 32'd1);
        #2 arstn = 1'b0;
        #1;
        check("ar_ena_async", 32'(ena_i2c), 32'd0);
        check("ar_gnt_async", 32'(gnt), 32'd0);
        check("ar_done_async", 32'(done), 32'd0);
        end_trans = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_done_hold", 32'(done), 32'd0);
        arstn = 1'b1;
        @(negedge clk);
        check("ar_done_after", 32'(done), 32'd0);
        check("ar_gnt_after", 32'(gnt), 32'd0);
        req_addr = {7'h34, 7'h01}; req_rnw = 2'b10; req_wdata = 16'h0000;
        byte_received = 8'h3C; req = 2'b10;
        run_txn("post_rst", 2'b10, 8'h69, 8'h00, 8'h3C, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
